// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file controller and its write arbiter.
package regfile_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef enum logic {
        REQ_WB,
        REQ_LD
    } req_id_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter: WB has priority unless LD has been refused STARVE_LIMIT
// consecutive cycles, after which LD wins one grant.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int WSIZE        = 4,
    parameter int STARVE_LIMIT = 4,
    localparam int DW          = WSIZE * 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_wb_valid,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [DW-1:0]     i_wb_data,
    input  logic              i_ld_valid,
    input  logic [REG_AW-1:0] i_ld_addr,
    input  logic [WSIZE-1:0]  i_ld_be,
    input  logic [DW-1:0]     i_ld_data,
    output logic              o_wb_ready,
    output logic              o_ld_ready,
    output logic              o_gnt_valid,
    output req_id_t           o_gnt_id,
    output logic [REG_AW-1:0] o_gnt_addr,
    output logic [DW-1:0]     o_gnt_data,
    output logic [WSIZE-1:0]  o_gnt_be
);

    logic [3:0] r_starve_cnt;
    logic       w_ld_starved;
    logic       w_wb_fire;
    logic       w_ld_fire;

    assign w_ld_starved = (r_starve_cnt == 4'(STARVE_LIMIT));

    // Both readys can be high together, but never with both valids, so at most one fires.
    assign o_wb_ready = i_en && !(w_ld_starved && i_ld_valid);
    assign o_ld_ready = i_en && (w_ld_starved || !i_wb_valid);

    assign w_wb_fire = i_wb_valid && o_wb_ready;
    assign w_ld_fire = i_ld_valid && o_ld_ready;

    assign o_gnt_valid = w_wb_fire || w_ld_fire;
    assign o_gnt_id    = w_ld_fire ? REQ_LD : REQ_WB;
    assign o_gnt_addr  = w_ld_fire ? i_ld_addr : i_wb_addr;
    assign o_gnt_data  = w_ld_fire ? i_ld_data : i_wb_data;
    assign o_gnt_be    = i_ld_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!i_en || !i_ld_valid || w_ld_fire) begin
            r_starve_cnt <= '0;
        end else if (!w_ld_starved) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Sequencer for the 1RW1R register-file macro: zero sweep after reset, then
// write-port arbitration, rs2 on port 0 when free, rs1 on port 1 with forwarding.
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int WSIZE        = 4,
    parameter int STARVE_LIMIT = 4,
    localparam int DW          = WSIZE * 8
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              init_done,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DW-1:0]     wb_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [WSIZE-1:0]  ld_be,
    input  logic [DW-1:0]     ld_data,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic [DW-1:0]     rs1_data,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [DW-1:0]     rs2_data,
    output logic              rs2_valid,
    output logic              ram_en0,
    output logic              ram_en1,
    output logic [WSIZE-1:0]  ram_we0,
    output logic [REG_AW-1:0] ram_a0,
    output logic [REG_AW-1:0] ram_a1,
    output logic [DW-1:0]     ram_di0,
    input  logic [DW-1:0]     ram_do0,
    input  logic [DW-1:0]     ram_do1
);

    state_t            r_state;
    logic [REG_AW-1:0] r_idx;
    logic              r_init_done;

    logic              w_run;
    logic              w_gnt_valid;
    req_id_t           w_gnt_id;
    logic [REG_AW-1:0] w_gnt_addr;
    logic [DW-1:0]     w_gnt_data;
    logic [WSIZE-1:0]  w_gnt_be;
    logic [WSIZE-1:0]  w_wr_be;
    logic              w_wr_nz;
    logic              w_rs2_free;

    assign w_run = (r_state == RUN);

    regfile_wr_arb #(
        .WSIZE        (WSIZE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_wr_arb (
        .clk         (CLK),
        .rst         (RST),
        .i_en        (w_run),
        .i_wb_valid  (wb_valid),
        .i_wb_addr   (wb_addr),
        .i_wb_data   (wb_data),
        .i_ld_valid  (ld_valid),
        .i_ld_addr   (ld_addr),
        .i_ld_be     (ld_be),
        .i_ld_data   (ld_data),
        .o_wb_ready  (wb_ready),
        .o_ld_ready  (ld_ready),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id),
        .o_gnt_addr  (w_gnt_addr),
        .o_gnt_data  (w_gnt_data),
        .o_gnt_be    (w_gnt_be)
    );

    // WB always writes the whole word; only LD carries partial byte lanes.
    assign w_wr_be = (w_gnt_id == REQ_LD) ? w_gnt_be : '1;
    assign w_wr_nz = w_gnt_valid && (w_gnt_addr != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= INIT;
            r_idx       <= REG_AW'(1);
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_idx == REG_AW'(NUM_REGS - 1)) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx + REG_AW'(1);
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign init_done = r_init_done;

    // RST gates the write strobe so an abort never lets the macro's negedge write land.
    always_comb begin
        ram_en0    = 1'b0;
        ram_we0    = '0;
        ram_a0     = rs2_addr;
        ram_di0    = '0;
        w_rs2_free = 1'b0;
        if (!RST) begin
            ram_en0 = 1'b1;
            if (r_state == INIT) begin
                ram_a0  = r_idx;
                ram_we0 = '1;
            end else if (w_wr_nz) begin
                ram_a0  = w_gnt_addr;
                ram_di0 = w_gnt_data;
                ram_we0 = w_wr_be;
            end else begin
                w_rs2_free = 1'b1;
            end
        end
    end

    assign rs2_valid = w_rs2_free;
    assign rs2_data  = (w_rs2_free && rs2_addr != '0) ? ram_do0 : '0;

    assign ram_en1 = w_run;
    assign ram_a1  = rs1_addr;

    always_comb begin
        rs1_data = ram_do1;
        if (w_wr_nz && w_gnt_addr == rs1_addr) begin
            for (int unsigned b = 0; b < WSIZE; b++) begin
                if (w_wr_be[b]) rs1_data[b*8 +: 8] = w_gnt_data[b*8 +: 8];
            end
        end
        if (rs1_addr == '0) rs1_data = '0;
    end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Sequencer and write-port arbiter for the 32-entry 1RW1R register-file RAM macro, which has one write/read port (A0) and one read-only port (A1). After reset it sweeps zeros into x1..x31, then arbitrates the single write port between core writeback (WB) and late load-return (LD), with LD anti-starvation. It routes rs1 reads to port 1 and rs2 reads to port 0 when port 0 is free. It also forces x0 reads to zero and forwards same-cycle writes to rs1.

Parameters:
WSIZE, 4, bytes per register word; data width DW = WSIZE*8
STARVE_LIMIT, 4, consecutive cycles LD may be refused before it gets priority (range 1..15)

Ports:
CLK  in  1  clock; the RAM macro writes on its negedge
RST  in  1  asynchronous, active-high reset
init_done  out  1  high once the zero sweep has completed
wb_valid  in  1  writeback write request
wb_ready  out  1  writeback accepted this cycle
wb_addr  in  5  writeback register index
wb_data  in  DW  writeback data (full word)
ld_valid  in  1  load-return write request
ld_ready  out  1  load-return accepted this cycle
ld_addr  in  5  load-return register index
ld_be  in  WSIZE  load-return byte enables
ld_data  in  DW  load-return data
rs1_addr  in  5  read index, served by port 1
rs1_data  out  DW  rs1 read data
rs2_addr  in  5  read index, served by port 0
rs2_data  out  DW  rs2 read data
rs2_valid  out  1  rs2_data is valid this cycle
ram_en0  out  1  RAM EN0
ram_en1  out  1  RAM EN1
ram_we0  out  WSIZE  RAM WE0 byte enables
ram_a0  out  5  RAM A0
ram_a1  out  5  RAM A1
ram_di0  out  DW  RAM Di0
ram_do0  in  DW  RAM Do0
ram_do1  in  DW  RAM Do1

Behaviour:
- Reset state while RST is high: state=INIT, sweep index=1, starve_cnt=0. Outputs: init_done=0, wb_ready=0, ld_ready=0, rs2_valid=0, ram_we0=0.
- RST asserted at any time, including mid-sweep or mid-handshake, aborts immediately. Nothing is partially written.
- INIT state:
  - Each cycle: ram_a0=idx, ram_di0=0, ram_we0=all ones, ram_en0=1.
  - idx runs 1..31, one register per cycle.
  - After idx=31 the next state is RUN. init_done rises on the first RUN cycle, exactly 31 cycles after reset release.
  - No requests are accepted during INIT.
- RUN state: ready/grant logic is combinational from the current inputs and starve_cnt.
  - ld_starved = (starve_cnt == STARVE_LIMIT).
  - wb_ready = !(ld_starved && ld_valid).
  - ld_ready = ld_starved || !wb_valid.
  - Handshake completes when valid && ready in the same cycle. At most one write is granted per cycle.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when ld_valid && !ld_ready.
  - Clears to 0 when LD is accepted or ld_valid=0.
- Granted write to a nonzero address:
  - ram_a0 = write address, ram_di0 = write data, ram_en0 = 1.
  - ram_we0 = all ones for WB; ram_we0 = ld_be for LD.
- Granted write to address 0: handshake completes, ram_we0=0, port 0 stays free.
- rs2 read:
  - When port 0 is not used by a write: ram_a0 = rs2_addr, rs2_valid = 1, rs2_data = ram_do0.
  - Otherwise rs2_valid = 0 and the core must hold rs2_addr.
- rs1 read:
  - ram_a1 = rs1_addr, ram_en1 = 1 in RUN.
  - If a nonzero-address write is granted this cycle to rs1_addr: bytes with an active enable come from the write data, other bytes from ram_do1. Gives a stable value for the whole cycle.
- x0: reading address 0 on either port returns all zeros, overriding RAM data and forwarding.
- Write/read ordering: a write completed in cycle N is visible through the RAM from cycle N+1 onward.

Decomposition:
- Shared package regfile_pkg:
  - REG_AW=5, NUM_REGS=32.
  - State enum {INIT, RUN}.
  - Requester id enum {REQ_WB, REQ_LD}.
- Sub-module regfile_wr_arb: WB/LD priority plus starve_cnt. Outputs the two readys, the grant id, and the granted addr/data/byte-enables.
- regfile_ctrl instantiates regfile_wr_arb. It owns the init sweep, port muxing, forwarding and x0 masking.

Test Plan:
- Reset release with no requests -> ram_we0=F and ram_di0=0 for ram_a0=1..31 on consecutive cycles. init_done=1 on cycle 31; wb_ready/ld_ready stay 0 before that.
- RST pulsed when idx=10 -> sweep restarts at idx=1. init_done rises 31 cycles after the second release.
- WB writes x5=0xDEADBEEF while rs1_addr=5 -> rs1_data=0xDEADBEEF in the same cycle. Next cycle rs2_addr=5 gives rs2_valid=1 and rs2_data=0xDEADBEEF.
- wb_valid held high, ld_valid high (STARVE_LIMIT=4) -> ld_ready=0 for 4 cycles, then ld_ready=1 and wb_ready=0 for one cycle; starve_cnt returns to 0.
- LD to x7 with ld_be=0b0010, ld_data=0x0000AB00 over x7=0x11223344 -> x7=0x1122AB44. rs2_valid=0 during the write cycle.
- WB write to x0 with 0xFFFFFFFF -> wb_ready=1, ram_we0=0, rs2_valid=1. Reads of x0 on both ports return 0.
